speed_select_controller: RTL

- Upstream control stage for the Lab4 rate-divider/counter datapath.
- Turns two raw DE1 pushbuttons (active-low, bouncy, asynchronous) into the registered 2-bit Speed code consumed by the rate divider.
- Also emits a one-cycle SpeedChanged pulse. The top level ORs this pulse into the rate divider's reload path, so a new rate takes effect immediately.
- Per button: 2-flop synchronizer, counter-based debouncer, press-edge detector. A saturating or wrapping speed register is shared by both buttons.

---
 rtl/speed_select_controller.sv | 107 ++++++++++
 1 files changed

// File: rtl/speed_select_controller.sv
// Pushbutton-driven speed selector: two active-low keys are synchronized, debounced and
// edge-detected, then step a shared 2-bit speed code with a one-cycle change strobe.

module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             prev;
    logic [CNT_W-1:0] cnt;

    // Reset everything to the released level so reset release never looks like a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            prev   <= 1'b1;
            cnt    <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            prev  <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = prev & ~stable;

endmodule

module speed_select_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WRAP            = 0
) (
    input  logic       ClockIn,
    input  logic       Resetn,
    input  logic       KeyUp,
    input  logic       KeyDown,
    output logic [1:0] Speed,
    output logic       SpeedChanged
);
    logic       press_up;
    logic       press_down;
    logic [1:0] speed_next;
    logic       changed;

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_up (
        .clk     (ClockIn),
        .rst_n   (Resetn),
        .key_raw (KeyUp),
        .press   (press_up)
    );

    key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_down (
        .clk     (ClockIn),
        .rst_n   (Resetn),
        .key_raw (KeyDown),
        .press   (press_down)
    );

    // Simultaneous up/down presses cancel; the strobe only fires on a real value change.
    always_comb begin
        speed_next = Speed;
        if (press_up && !press_down) begin
            if (Speed == 2'b11) begin
                if (WRAP != 0) speed_next = 2'b00;
            end else begin
                speed_next = Speed + 2'd1;
            end
        end else if (press_down && !press_up) begin
            if (Speed == 2'b00) begin
                if (WRAP != 0) speed_next = 2'b11;
            end else begin
                speed_next = Speed - 2'd1;
            end
        end
        changed = (speed_next != Speed);
    end

    always_ff @(posedge ClockIn or negedge Resetn) begin
        if (!Resetn) begin
            Speed        <= 2'b00;
            SpeedChanged <= 1'b0;
        end else begin
            Speed        <= speed_next;
            SpeedChanged <= changed;
        end
    end

endmodule
